// File: rtl/datapath_pkg.sv
// Shared datapath types for the scalar load/store unit.
// LSU_SUBWORD_EN selects whether BYTE/HALF accesses are legal.
package datapath_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  // True when an access of this size cannot be issued at this byte offset.
  function automatic logic is_misaligned(lsu_size_t size, logic [1:0] lo);
    logic mis;
`ifdef LSU_SUBWORD_EN
    case (size)
      BYTE:    mis = 1'b0;
      HALF:    mis = lo[0];
      WORD:    mis = (lo != 2'b00);
      default: mis = 1'b1;  // encoding 3 is not a legal size
    endcase
`else
    mis = (size != WORD) || (lo != 2'b00);
`endif
    return mis;
  endfunction

endpackage

// File: rtl/scalar_lsu_align.sv
// Combinational lane steering for stores and extract/extend for loads.
// With LSU_SUBWORD_EN undefined only WORD traffic exists, so data passes
// straight through and all byte lanes are enabled.
module lsu_align
  import datapath_pkg::*;
(
  input  lsu_size_t   size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] store_o,
  output logic [3:0]  byten_o,
  output logic [31:0] load_o
);

`ifdef LSU_SUBWORD_EN
  logic [31:0] shifted;

  // Replicate store data across lanes and pick the byte enables.
  always_comb begin
    store_o = wdata_i;
    byten_o = 4'b1111;
    case (size_i)
      BYTE: begin
        store_o = {4{wdata_i[7:0]}};
        byten_o = 4'b0001 << addr_lo_i;
      end
      HALF: begin
        store_o = {2{wdata_i[15:0]}};
        byten_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_o = wdata_i;
        byten_o = 4'b1111;
      end
    endcase
  end

  // Move the addressed lane down to bit 0 and sign/zero extend it.
  always_comb begin
    shifted = rdata_i >> {addr_lo_i, 3'b000};
    load_o  = rdata_i;
    case (size_i)
      BYTE:    load_o = unsigned_i ? {24'h000000, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      HALF:    load_o = unsigned_i ? {16'h0000, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      default: load_o = rdata_i;
    endcase
  end
`else
  logic unused_ok;

  assign store_o   = wdata_i;
  assign byten_o   = '1;
  assign load_o    = rdata_i;
  assign unused_ok = ^{size_i, unsigned_i, addr_lo_i};
`endif

endmodule

// File: rtl/scalar_lsu.sv
// Scalar load/store unit: takes one memory op from issue, runs the
// data-memory handshake and returns extended load data to writeback.
// Build option LSU_SUBWORD_EN enables BYTE/HALF accesses.
module scalar_lsu
  import datapath_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_base,
  input  logic [31:0] req_imm,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic [3:0]  dmembyten,
  input  logic [31:0] dmemload_in,
  input  logic        dhit,
  output logic [31:0] dmemload,
  output logic        load_ready,
  output logic [4:0]  reg_sel_load,
  output logic        misalign
);

  lsu_state_t  state_q;
  word_t       ea_q;
  logic        we_q;
  lsu_size_t   size_q;
  logic        uns_q;
  word_t       wdata_q;
  regbits_t    rd_q;
  word_t       dmemload_q;
  regbits_t    reg_sel_q;
  logic        misalign_q;

  word_t       ea_d;
  lsu_size_t   size_d;
  logic        accept;
  logic        mis_d;
  word_t       store_w;
  logic [3:0]  byten_w;
  word_t       load_w;

  assign ea_d   = req_base + req_imm;
  assign size_d = lsu_size_t'(req_size);
  assign accept = req_valid && (state_q == IDLE);
  assign mis_d  = is_misaligned(size_d, ea_d[1:0]);

  lsu_align u_align (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .addr_lo_i  (ea_q[1:0]),
    .wdata_i    (wdata_q),
    .rdata_i    (dmemload_in),
    .store_o    (store_w),
    .byten_o    (byten_w),
    .load_o     (load_w)
  );

  // Request FSM: latches the op on accept, waits for dhit, captures load data.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      ea_q       <= '0;
      we_q       <= 1'b0;
      size_q     <= BYTE;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      rd_q       <= '0;
      dmemload_q <= '0;
      reg_sel_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            ea_q    <= ea_d;
            we_q    <= req_we;
            size_q  <= size_d;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
            if (mis_d) begin
              misalign_q <= 1'b1;
            end else begin
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          if (dhit) begin
            if (we_q) begin
              state_q <= IDLE;
            end else begin
              dmemload_q <= load_w;
              reg_sel_q  <= rd_q;
              state_q    <= RESP;
            end
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign dmemREN      = (state_q == REQ) && !we_q;
  assign dmemWEN      = (state_q == REQ) && we_q;
  assign dmemaddr     = {ea_q[31:2], 2'b00};
  assign dmemstore    = store_w;
  assign load_ready   = (state_q == RESP);
  assign dmemload     = dmemload_q;
  assign reg_sel_load = reg_sel_q;
  assign misalign     = misalign_q;

`ifdef LSU_SUBWORD_EN
  assign dmembyten = (state_q == REQ) ? byten_w : '0;
`else
  assign dmembyten = byten_w;
`endif

endmodule

// File: tb/tb_scalar_lsu.sv
// Directed bench for scalar_lsu: vector table plus reset and back-to-back sequences.
module tb_scalar_lsu;

`ifdef LSU_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        nRST;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_base, req_imm, req_wdata;
  logic [4:0]  req_rd;
  logic        dmemREN, dmemWEN, dhit, load_ready, misalign;
  logic [31:0] dmemaddr, dmemstore, dmemload_in, dmemload;
  logic [3:0]  dmembyten;
  logic [4:0]  reg_sel_load;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_load;

  always #5 CLK = ~CLK;

  scalar_lsu dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_base(req_base), .req_imm(req_imm), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dmembyten(dmembyten),
    .dmemload_in(dmemload_in), .dhit(dhit),
    .dmemload(dmemload), .load_ready(load_ready),
    .reg_sel_load(reg_sel_load), .misalign(misalign)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] base;
    logic [31:0] imm;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] mem;
    int unsigned dly;
    logic        mis;
    logic [31:0] addr;
    logic [31:0] store;
    logic [3:0]  byten;
    logic [31:0] load;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", nm, act, exp);
    end
  endtask

  task automatic set_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] base, input logic [31:0] imm,
                         input logic [31:0] wd, input logic [4:0] rd);
    req_we = we; req_size = sz; req_unsigned = uns;
    req_base = base; req_imm = imm; req_wdata = wd; req_rd = rd;
  endtask

  // Called at a negedge with the LSU idle; returns at a negedge with it idle.
  task automatic do_vec(input vec_t v);
    set_req(v.we, v.size, v.uns, v.base, v.imm, v.wdata, v.rd);
    dmemload_in = v.mem;
    req_valid   = 1'b1;
    chk("ready_before", {31'd0, req_ready}, 32'd1);
    @(negedge CLK);
    req_valid = 1'b0;
    if (v.mis) begin
      chk("mis_pulse", {31'd0, misalign}, 32'd1);
      chk("mis_strobes", {30'd0, dmemREN, dmemWEN}, 32'd0);
      chk("mis_ready", {31'd0, req_ready}, 32'd1);
      @(negedge CLK);
      chk("mis_end", {31'd0, misalign}, 32'd0);
      chk("mis_strobes2", {30'd0, dmemREN, dmemWEN}, 32'd0);
      chk("mis_hold", dmemload, last_load);
    end else begin
      for (int unsigned k = 0; k <= v.dly; k++) begin
        chk("req_ren", {31'd0, dmemREN}, {31'd0, ~v.we});
        chk("req_wen", {31'd0, dmemWEN}, {31'd0, v.we});
        chk("req_addr", dmemaddr, v.addr);
        chk("req_byten", {28'd0, dmembyten}, {28'd0, SUB ? v.byten : 4'hF});
        chk("req_ready_low", {31'd0, req_ready}, 32'd0);
        if (v.we) chk("req_store", dmemstore, v.store);
        dhit = (k == v.dly);
        @(negedge CLK);
      end
      dhit = 1'b0;
      if (v.we) begin
        chk("st_no_ld", {31'd0, load_ready}, 32'd0);
        chk("st_done_ready", {31'd0, req_ready}, 32'd1);
        chk("st_strobes_off", {30'd0, dmemREN, dmemWEN}, 32'd0);
        chk("st_hold", dmemload, last_load);
      end else begin
        chk("ld_ready", {31'd0, load_ready}, 32'd1);
        chk("ld_data", dmemload, v.load);
        chk("ld_rd", {27'd0, reg_sel_load}, {27'd0, v.rd});
        chk("ld_strobe_off", {31'd0, dmemREN}, 32'd0);
        last_load = v.load;
        @(negedge CLK);
        chk("ld_pulse_end", {31'd0, load_ready}, 32'd0);
        chk("ld_hold", dmemload, v.load);
        chk("ld_idle_ready", {31'd0, req_ready}, 32'd1);
      end
    end
  endtask

  initial begin
    int unsigned acc[3];
    int unsigned n;
    int unsigned lpulses;

    //          we  sz    uns  base          imm           wdata         rd     mem           dly mis  addr          store         byten  load
    vecs[0] = '{1'b0, 2'd2, 1'b0, 32'h00000100, 32'h00000004, 32'h0,        5'd5,  32'hDEADBEEF, 2, 1'b0, 32'h00000104, 32'h0,        4'hF, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 2'd0, 1'b0, 32'h00000100, 32'h00000003, 32'h0,        5'd7,  32'h80FF1234, 0, 1'b0, 32'h00000100, 32'h0,        4'h8, 32'hFFFFFF80};
    vecs[2] = '{1'b0, 2'd0, 1'b1, 32'h00000100, 32'h00000003, 32'h0,        5'd8,  32'h80FF1234, 0, 1'b0, 32'h00000100, 32'h0,        4'h8, 32'h00000080};
    vecs[3] = '{1'b1, 2'd1, 1'b0, 32'h00000200, 32'h00000002, 32'h1234ABCD, 5'd0,  32'h0,        1, 1'b0, 32'h00000200, 32'hABCDABCD, 4'hC, 32'h0};
    vecs[4] = '{1'b0, 2'd2, 1'b0, 32'h00000100, 32'h00000001, 32'h0,        5'd3,  32'h0,        0, 1'b1, 32'h0,        32'h0,        4'h0, 32'h0};
    vecs[5] = '{1'b0, 2'd1, 1'b0, 32'h00000100, 32'h00000002, 32'h0,        5'd9,  32'h80010000, 1, 1'b0, 32'h00000100, 32'h0,        4'hC, 32'hFFFF8001};
    vecs[6] = '{1'b1, 2'd0, 1'b0, 32'h00000305, 32'hFFFFFFFC, 32'h000000A5, 5'd0,  32'h0,        0, 1'b0, 32'h00000300, 32'hA5A5A5A5, 4'h2, 32'h0};
    vecs[7] = '{1'b1, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h00000404, 32'hCAFEF00D, 5'd0,  32'h0,        3, 1'b0, 32'h00000400, 32'hCAFEF00D, 4'hF, 32'h0};
    vecs[8] = '{1'b0, 2'd1, 1'b0, 32'h00000100, 32'h00000001, 32'h0,        5'd4,  32'h0,        0, 1'b1, 32'h0,        32'h0,        4'h0, 32'h0};
    vecs[9] = '{1'b0, 2'd1, 1'b1, 32'h00000100, 32'h00000000, 32'h0,        5'd31, 32'h1234F00F, 0, 1'b0, 32'h00000100, 32'h0,        4'h3, 32'h0000F00F};
    if (!SUB) begin
      foreach (vecs[i]) if (vecs[i].size != 2'd2) vecs[i].mis = 1'b1;
    end

    nRST = 1'b0; req_valid = 1'b0; dhit = 1'b0; dmemload_in = '0;
    set_req(1'b0, 2'd0, 1'b0, '0, '0, '0, '0);
    last_load = '0;
    repeat (2) @(negedge CLK);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_strobes", {30'd0, dmemREN, dmemWEN}, 32'd0);
    chk("rst_addr", dmemaddr, 32'd0);
    chk("rst_store", dmemstore, 32'd0);
    chk("rst_byten", {28'd0, dmembyten}, {28'd0, SUB ? 4'h0 : 4'hF});
    chk("rst_load", dmemload, 32'd0);
    chk("rst_flags", {30'd0, load_ready, misalign}, 32'd0);
    chk("rst_rd", {27'd0, reg_sel_load}, 32'd0);
    nRST = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 10; i++) do_vec(vecs[i]);

    // Reset in the middle of a pending load.
    set_req(1'b0, 2'd2, 1'b0, 32'h00000500, 32'h0, 32'h0, 5'd6);
    req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    chk("mid_ren", {31'd0, dmemREN}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("mid_ren_drop", {31'd0, dmemREN}, 32'd0);
    chk("mid_ready", {31'd0, req_ready}, 32'd1);
    @(negedge CLK);
    nRST = 1'b1;
    dhit = 1'b1;
    last_load = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("mid_no_ld", {31'd0, load_ready}, 32'd0);
      chk("mid_no_ren", {31'd0, dmemREN}, 32'd0);
    end
    dhit = 1'b0;
    do_vec(vecs[0]);

    // Back-to-back: store, load, store with dhit always high.
    n = 0; lpulses = 0; acc[0] = 0; acc[1] = 0; acc[2] = 0;
    dhit = 1'b1;
    dmemload_in = 32'h11223344;
    set_req(1'b1, 2'd2, 1'b0, 32'h00000600, 32'h0, 32'h55AA55AA, 5'd0);
    req_valid = 1'b1;
    for (int unsigned k = 0; k < 30 && n < 3; k++) begin
      if (load_ready) begin
        lpulses++;
        chk("b2b_ld_data", dmemload, 32'h11223344);
        chk("b2b_ld_rd", {27'd0, reg_sel_load}, 32'd12);
      end
      if (req_valid && req_ready) begin
        acc[n] = k;
        n++;
        @(posedge CLK);
        #1;
        if (n == 1) set_req(1'b0, 2'd2, 1'b0, 32'h00000600, 32'h4, 32'h0, 5'd12);
        else if (n == 2) set_req(1'b1, 2'd2, 1'b0, 32'h00000608, 32'h0, 32'h0, 5'd0);
        else req_valid = 1'b0;
      end
      @(negedge CLK);
    end
    req_valid = 1'b0;
    chk("b2b_accepts", n, 32'd3);
    chk("b2b_st_gap", acc[1] - acc[0], 32'd2);
    chk("b2b_ld_gap", acc[2] - acc[1], 32'd3);
    chk("b2b_ld_pulses", lpulses, 32'd1);
    repeat (2) @(negedge CLK);
    dhit = 1'b0;
    chk("b2b_idle", {31'd0, req_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
